// File: rtl/alu_op_div.sv
// alu_op_div: iterative unsigned restoring divider.
// Recovers X3 = F / d and R = F % d one quotient bit per clock, with
// valid/ready handshakes on both sides. A zero divisor skips the iteration
// and returns an all-ones quotient with the dividend as remainder.
module alu_op_div #(
  parameter int N = 10
) (
  input  logic         clk1,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] F,
  input  logic [N-1:0] d,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] X3,
  output logic [N-1:0] R,
  output logic         div_zero
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  // Partial remainder carries one spare bit so the shifted value never
  // overflows when the divisor has its MSB set.
  logic [N:0]    rem_reg;
  logic [N-1:0]  quo_reg;
  logic [N-1:0]  div_reg;

  logic [N+1:0]  rem_shift;
  logic [N+1:0]  trial;
  logic          trial_neg;
  logic [N:0]    rem_next;
  logic [N-1:0]  quo_next;

  // One restoring step: shift {rem, quo} left, try subtracting the divisor,
  // keep the difference only when it did not go negative.
  always_comb begin
    rem_shift = {rem_reg, quo_reg[N-1]};
    trial     = rem_shift - {2'b00, div_reg};
    trial_neg = trial[N+1];
    rem_next  = trial_neg ? rem_shift[N:0] : trial[N:0];
    quo_next  = {quo_reg[N-2:0], ~trial_neg};
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk1) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      rem_reg   <= '0;
      quo_reg   <= '0;
      div_reg   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      X3        <= '0;
      R         <= '0;
      div_zero  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (d != '0) begin
              quo_reg   <= F;
              div_reg   <= d;
              rem_reg   <= '0;
              cnt_reg   <= CW'(N - 1);
              div_zero  <= 1'b0;
              state_reg <= CALC;
            end else begin
              // Division by zero is answered immediately.
              X3        <= '1;
              R         <= F;
              div_zero  <= 1'b1;
              out_valid <= 1'b1;
              state_reg <= DONE;
            end
          end
        end
        CALC: begin
          rem_reg <= rem_next;
          quo_reg <= quo_next;
          cnt_reg <= cnt_reg - 1'b1;
          if (cnt_reg == '0) begin
            X3        <= quo_next;
            R         <= rem_next[N-1:0];
            out_valid <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          // Result is held until downstream takes it.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_div.sv
// tb_alu_op_div: directed and randomized checks of alu_op_div against a
// plain arithmetic reference (F/d, F%d, div-zero rule).
module tb_alu_op_div;

  localparam int N = 10;

  logic         clk1;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] F;
  logic [N-1:0] d;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] X3;
  logic [N-1:0] R;
  logic         div_zero;

  int pass_cnt  = 0;
  int total_cnt = 0;

  alu_op_div #(.N(N)) dut (
    .clk1      (clk1),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .F         (F),
    .d         (d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .X3        (X3),
    .R         (R),
    .div_zero  (div_zero)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  function automatic int ref_q(input int fi, input int di);
    return (di == 0) ? ((1 << N) - 1) : fi / di;
  endfunction

  function automatic int ref_r(input int fi, input int di);
    return (di == 0) ? fi : fi % di;
  endfunction

  function automatic logic [N-1:0] rand_div();
    int sel;
    sel = int'($urandom_range(7));
    if (sel == 0) return '0;
    if (sel == 1) return N'(1);
    return N'($urandom);
  endfunction

  // One operation: accept, measure latency, check result, optionally
  // stall the output for 'hold' cycles, then release it.
  task automatic run_op(input logic [N-1:0] f, input logic [N-1:0] dd, input int hold);
    int w, lat, eq, er, exp_lat;
    bit busy_ok;
    w = 0;
    while (!in_ready && w < 50) begin step(); w++; end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    F = f; d = dd; in_valid = 1'b1;
    out_ready = (hold == 0);
    step();
    in_valid = 1'b0;
    F = N'($urandom); d = N'($urandom);
    lat = 0; busy_ok = 1'b1;
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_ok = 1'b0;
      step();
      lat++;
    end
    eq = ref_q(int'(f), int'(dd));
    er = ref_r(int'(f), int'(dd));
    exp_lat = (dd == 0) ? 0 : N;
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("X3", 32'(X3), 32'(eq));
    chk("R", 32'(R), 32'(er));
    chk("div_zero", 32'(div_zero), 32'(dd == 0));
    chk("in_ready_busy", 32'(busy_ok && !in_ready), 32'd1);
    $display("op F=%0d d=%0d -> X3=%0d R=%0d dz=%0d lat=%0d", f, dd, X3, R, div_zero, lat);
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_X3", 32'(X3), 32'(eq));
      chk("hold_R", 32'(R), 32'(er));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    step();
    chk("release_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
  endtask

  int exp_q[$];
  int exp_r[$];
  int exp_z[$];
  int sent, recv, cyc;
  bit acc, con;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; F = '0; d = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_X3", 32'(X3), 32'd0);
    chk("rst_R", 32'(R), 32'd0);
    chk("rst_div_zero", 32'(div_zero), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Basic operation and boundary operands.
    run_op(N'(100), N'(7), 0);
    run_op(N'(1023), N'(1), 0);
    run_op(N'(1023), N'(1023), 0);
    run_op(N'(3), N'(9), 0);
    // Divide by zero, then a normal op right after.
    run_op(N'(5), N'(0), 0);
    run_op(N'(9), N'(3), 0);
    // Divisor MSB set, output stalled 5 cycles.
    run_op(N'(600), N'(513), 5);

    // Reset in the middle of CALC discards the operation.
    F = N'(200); d = N'(3); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_X3", 32'(X3), 32'd0);
    chk("midrst_R", 32'(R), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    step();
    chk("midrst_no_output", 32'(out_valid), 32'd0);
    run_op(N'(200), N'(3), 0);

    // Random back-to-back stream with random backpressure.
    sent = 0; recv = 0; cyc = 0;
    while (recv < 200 && cyc < 20000) begin
      if (!in_valid && sent < 200 && $urandom_range(3) != 0) begin
        F = N'($urandom);
        d = rand_div();
        in_valid = 1'b1;
      end
      out_ready = 1'($urandom_range(1));
      acc = in_valid && in_ready;
      con = out_valid && out_ready;
      if (acc) begin
        exp_q.push_back(ref_q(int'(F), int'(d)));
        exp_r.push_back(ref_r(int'(F), int'(d)));
        exp_z.push_back(int'(d == 0));
        sent++;
      end
      if (con) begin
        if (exp_q.size() == 0) begin
          chk("rand_unexpected_output", 32'd1, 32'd0);
        end else begin
          $display("rand op %0d: X3=%0d R=%0d dz=%0d exp X3=%0d R=%0d dz=%0d",
                   recv, X3, R, div_zero, exp_q[0], exp_r[0], exp_z[0]);
          chk("rand_X3", 32'(X3), 32'(exp_q.pop_front()));
          chk("rand_R", 32'(R), 32'(exp_r.pop_front()));
          chk("rand_dz", 32'(div_zero), 32'(exp_z.pop_front()));
        end
        recv++;
      end
      step();
      cyc++;
      if (acc) in_valid = 1'b0;
    end
    chk("rand_received", 32'(recv), 32'd200);
    chk("rand_pending", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
